// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types, default sizing and the rotate-priority pick used by the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_MAX_BURST  = 4;

  // Index of the first set bit of req searching ptr, ptr+1, ... with wrap at n; -1 when none.
  function automatic int rot_pick(input logic [31:0] req, input int unsigned ptr,
                                  input int unsigned n);
    int unsigned idx;
    rot_pick = -1;
    for (int unsigned k = 0; k < 32; k++) begin
      idx = (ptr + k) % n;
      if (k < n && rot_pick < 0 && req[idx]) rot_pick = int'(idx);
    end
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: one-hot winner and its index, starting the search at ptr.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N     = DEF_N_REQ,
  parameter int PTR_W = $clog2(DEF_N_REQ)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  int pick;

  always_comb begin
    pick   = rot_pick(32'(req), 32'(ptr), N);
    valid  = (pick >= 0);
    idx    = valid ? PTR_W'(pick) : '0;
    winner = valid ? (N'(1) << pick) : '0;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ producers, with sticky error monitor.
// Build option ARB_AFULL_THROTTLE_EN: almostfull ends bursts and blocks new grants.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            ready,
  output logic [N_REQ-1:0]            grant,
  output logic [FIFO_WIDTH-1:0]       data_in,
  output logic                        wr_en,
  input  logic                        full,
  input  logic                        almostfull,
  input  logic                        wr_ack,
  input  logic                        overflow,
  output logic                        err_ovf,
  output logic                        err_ack
);

  // state | meaning
  // IDLE  | no owner; pick the next requester from ptr, no transfer this cycle
  // BURST | grant held; words move on req&&ready until burst limit or req drops

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [0:0] S_IDLE  = ARB_IDLE;
  localparam logic [0:0] S_BURST = ARB_BURST;

  logic [0:0]       state;
  logic [N_REQ-1:0] grant_q;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic [CNT_W-1:0] burst_cnt;
  logic             pending;

  logic [N_REQ-1:0] pick_onehot;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_valid;
  logic             throttle;
  logic             last_word;

`ifdef ARB_AFULL_THROTTLE_EN
  assign throttle = almostfull;
`else
  logic unused_almostfull;
  assign unused_almostfull = almostfull;
  assign throttle          = 1'b0;
`endif

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign grant     = grant_q;
  assign ready     = full ? '0 : grant_q;
  assign wr_en     = |(req & ready);
  assign data_in   = wr_en ? req_data[gnt_idx*FIFO_WIDTH +: FIFO_WIDTH] : '0;
  assign last_word = (burst_cnt == CNT_W'(MAX_BURST - 1)) || throttle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      grant_q   <= '0;
      ptr       <= '0;
      gnt_idx   <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid && !throttle) begin
            grant_q   <= pick_onehot;
            gnt_idx   <= pick_idx;
            ptr       <= (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            burst_cnt <= '0;
            state     <= S_BURST;
          end
        end
        default: begin
          // Dropping req without a transfer surrenders the grant.
          if (!req[gnt_idx]) begin
            grant_q <= '0;
            state   <= S_IDLE;
          end else if (wr_en) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (last_word) begin
              grant_q <= '0;
              state   <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  // wr_ack/overflow are registered in the FIFO, so they answer the previous cycle's wr_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      err_ovf <= 1'b0;
      err_ack <= 1'b0;
    end else begin
      pending <= wr_en;
      if (overflow) err_ovf <= 1'b1;
      if (pending && !wr_ack && !overflow) err_ack <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   ready, grant;
  logic [W-1:0]   data_in;
  logic           wr_en, full, almostfull, wr_ack, overflow, err_ovf, err_ack;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .ready      (ready),
    .grant      (grant),
    .data_in    (data_in),
    .wr_en      (wr_en),
    .full       (full),
    .almostfull (almostfull),
    .wr_ack     (wr_ack),
    .overflow   (overflow),
    .err_ovf    (err_ovf),
    .err_ack    (err_ack)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] word[N];

  // Behavioural model: current owner (-1 = nobody), next search start, words taken in this burst.
  int owner = -1;
  int rr_next = 0;
  int taken = 0;
  bit m_pend = 0, m_ovf = 0, m_ack = 0;
  bit force_ovf = 0, kill_ack = 0;
  bit exp_wr = 0;
  int last_acc = -1;
  int wr_count = 0;
  logic act_wr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = word[i];
  endtask

  task automatic model_edge();
    bit thr;
`ifdef ARB_AFULL_THROTTLE_EN
    thr = almostfull;
`else
    thr = 1'b0;
`endif
    if (rst) begin
      owner = -1; rr_next = 0; taken = 0;
      m_pend = 0; m_ovf = 0; m_ack = 0;
    end else begin
      if (overflow) m_ovf = 1;
      if (m_pend && !wr_ack && !overflow) m_ack = 1;
      m_pend = exp_wr;
      if (owner < 0) begin
        if (req != '0 && !thr) begin
          for (int k = 0; k < N; k++)
            if (owner < 0 && req[(rr_next + k) % N]) owner = (rr_next + k) % N;
          rr_next = (owner + 1) % N;
          taken = 0;
        end
      end else if (!req[owner]) begin
        owner = -1;
      end else if (exp_wr) begin
        taken++;
        if (taken == MB || thr) owner = -1;
      end
    end
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic step();
    logic [N-1:0] eg;
    logic [W-1:0] ed;
    wr_ack   = m_pend && !kill_ack;
    overflow = force_ovf;
    #1;
    eg     = (owner >= 0) ? (N'(1) << owner) : '0;
    exp_wr = (owner >= 0) && req[owner] && !full;
    ed     = '0;
    if (exp_wr) ed = req_data[owner*W +: W];
    act_wr = wr_en;
    chk("grant", 64'(grant), 64'(eg));
    chk("ready", 64'(ready), 64'(full ? '0 : eg));
    chk("wr_en", 64'(wr_en), 64'(exp_wr));
    chk("err_ovf", 64'(err_ovf), 64'(m_ovf));
    chk("err_ack", 64'(err_ack), 64'(m_ack));
    if (exp_wr) begin
      exp_q.push_back(ed);
      wr_count++;
    end
    last_acc = exp_wr ? owner : -1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; full = 1'b0; almostfull = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Monitor: every presented write must match the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got data 0x%0h expected no write at %0t", data_in, $time);
        end else begin
          chk("data_in", 64'(data_in), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [9:0] pattern;
    rst = 1'b1; req = '0; req_data = '0; full = 1'b0; almostfull = 1'b0;
    wr_ack = 1'b0; overflow = 1'b0;
    for (int i = 0; i < N; i++) word[i] = W'(16'hA000 + i * 16'h0111);
    set_data();
    @(negedge clk);

    // Reset holds everything quiet even with all producers requesting.
    req = 4'b1111;
    step();
    step();
    rst = 1'b0;
    step();
    chk("t1_first_grant", 64'(grant), 64'(4'b0001));

    // Two requesters alternate full bursts with one idle cycle between.
    do_reset();
    req = 4'b0101;
    step();
    pattern = '0;
    for (int c = 0; c < 10; c++) begin
      step();
      pattern = {pattern[8:0], act_wr};
    end
    chk("t2_wr_pattern", 64'(pattern), 64'(10'b1111011110));

    // full stalls producer1 mid-burst without losing its grant or count.
    do_reset();
    req = 4'b0010;
    base = wr_count;
    step();
    step();
    full = 1'b1;
    for (int c = 0; c < 3; c++) step();
    chk("t3_grant_held", 64'(grant), 64'(4'b0010));
    full = 1'b0;
    for (int c = 0; c < 3; c++) step();
    chk("t3_words", 64'(wr_count - base), 64'(4));
    chk("t3_burst_end", 64'(grant), 64'(0));
    req = '0;
    step();

    // Producer3 sends two words and drops; pointer wraps to producer0.
    do_reset();
    req = 4'b1000;
    base = wr_count;
    step();
    step();
    step();
    chk("t4_words", 64'(wr_count - base), 64'(2));
    req = 4'b0001;
    step();
    chk("t4_idle", 64'(grant), 64'(0));
    step();
    chk("t4_wrap_grant", 64'(grant), 64'(4'b0001));

    // Sticky error flags.
    do_reset();
    req = 4'b0001;
    step();
    step();
    force_ovf = 1'b1;
    step();
    force_ovf = 1'b0;
    chk("t5_ovf_set", 64'(err_ovf), 64'(1));
    kill_ack = 1'b1;
    step();
    kill_ack = 1'b0;
    chk("t5_ack_set", 64'(err_ack), 64'(1));
    for (int c = 0; c < 4; c++) step();
    chk("t5_sticky", 64'({err_ovf, err_ack}), 64'(2'b11));
    do_reset();
    chk("t5_cleared", 64'({err_ovf, err_ack}), 64'(2'b00));

`ifdef ARB_AFULL_THROTTLE_EN
    // almostfull cuts the burst after the word it coincides with and blocks regranting.
    req = 4'b0001;
    base = wr_count;
    step();
    step();
    almostfull = 1'b1;
    step();
    chk("t6_words", 64'(wr_count - base), 64'(2));
    step();
    step();
    chk("t6_no_grant", 64'(grant), 64'(0));
    almostfull = 1'b0;
    step();
    chk("t6_regrant", 64'(grant), 64'(4'b0001));
    do_reset();
`endif

    // Randomized traffic: requests flicker, full/almostfull toggle, rare resets.
    for (int c = 0; c < 1500; c++) begin
      rst        = ($urandom_range(0, 299) == 0);
      full       = ($urandom_range(0, 4) == 0);
      almostfull = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) req[i] = ($urandom_range(0, 5) != 0);
      set_data();
      step();
      if (last_acc >= 0) word[last_acc] = W'($urandom);
    end

    rst = 1'b0; req = '0; full = 1'b0; almostfull = 1'b0;
    for (int c = 0; c < 3; c++) step();
    chk("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin, burst-based arbiter that shares the single FIFO write port among N_REQ producers.
- Grants one producer at a time.
- Muxes its data onto data_in/wr_en of the FIFO.
- Honours full backpressure.
- Records sticky protocol errors from the FIFO's overflow and wr_ack feedback.
- Sits between producer agents and the FIFO write side; read side untouched.

Parameters:
N_REQ, 4, number of producers (>=2)
FIFO_WIDTH, 16, data word width; must match the FIFO
MAX_BURST, 4, max words per grant before forced rotation (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
req  input  N_REQ  per-producer valid
req_data  input  N_REQ*FIFO_WIDTH  flattened producer words; producer i at [i*FIFO_WIDTH +: FIFO_WIDTH]
ready  output  N_REQ  per-producer accept; word moves when req[i]&&ready[i]
grant  output  N_REQ  one-hot current owner, zero in IDLE
data_in  output  FIFO_WIDTH  to FIFO data_in
wr_en  output  1  to FIFO wr_en
full  input  1  from FIFO
almostfull  input  1  from FIFO
wr_ack  input  1  from FIFO (registered, one cycle after write)
overflow  input  1  from FIFO (registered)
err_ovf  output  1  sticky: FIFO reported overflow
err_ack  output  1  sticky: write issued but no wr_ack/overflow next cycle

Behaviour:
Reset (sync, rst=1 at posedge):
- State=IDLE, grant=0, ptr=0, burst_cnt=0, err_ovf=0, err_ack=0, pending=0.
- Combinational outputs follow: ready=0, wr_en=0, data_in=0.

FSM states IDLE, BURST:
- IDLE: if |req, pick the first set bit searching from ptr upward with wrap (ptr, ptr+1, ..., N_REQ-1, 0, ...). Register grant one-hot, set ptr=winner+1 mod N_REQ, burst_cnt=0, go BURST. No transfer in IDLE.
- BURST: ready[i] = grant[i] && !full (combinational). wr_en = |(req & ready). data_in = req_data of granted index when wr_en, else 0. Zero latency from req to wr_en.
- Each transfer increments burst_cnt (width clog2(MAX_BURST+1)).
- BURST -> IDLE with grant cleared next cycle when:
  - a transfer makes burst_cnt reach MAX_BURST; or
  - req[granted] is low.
- full while granted: ready=0, stay in BURST, grant held, counter frozen. No timeout.
- Rotation costs exactly one IDLE cycle between grants. Peak throughput is MAX_BURST/(MAX_BURST+1) with multiple requesters.
- A producer must hold req and data stable until accepted. Dropping req without a transfer ends its grant.
- Reqs arriving during BURST wait. Reqs dropped during IDLE are not granted.

Error monitor:
- pending <= wr_en each cycle.
- err_ovf set when overflow=1.
- err_ack set when pending=1 && wr_ack=0 && overflow=0.
- Both sticky until rst.
- overflow=1 should never occur since wr_en is gated by full; it flags FIFO/arbiter disagreement.

Reset mid-burst: abandons grant; the word presented in that cycle is not written (wr_en is still combinational that cycle, but the FIFO's own reset governs it; a bench must hold rst≥1 cycle).

Optional Feature:
ARB_AFULL_THROTTLE_EN
- Defined: in BURST, a transfer while almostfull=1 ends the burst (-> IDLE) regardless of burst_cnt. In IDLE, no grant is issued while almostfull=1. This leaves headroom for other FIFO writers.
- Undefined: almostfull ignored (port present, unused).

Decomposition:
- Package fifo_arb_pkg: state enum (IDLE, BURST) typedef, default parameter constants, function for a rotate-priority one-hot pick.
- One sub-module: rr_pick — combinational round-robin selector (req, ptr -> one-hot winner, valid). Instantiated once. Keeps the FSM file to sequencing only.

Test Plan:
1. rst=1 two cycles, req=4'b1111 -> grant=0, wr_en=0, err_*=0 throughout; first grant=0001 one cycle after rst falls.
2. req=4'b0101 held, full=0, MAX_BURST=4 -> 4 writes of producer0 data, 1 idle cycle, 4 writes of producer2 data, then back to 0; wr_en pattern 1111_0_1111_0.
3. Granted producer1, full=1 for 3 cycles mid-burst -> ready=0, wr_en=0, grant stays 0010, burst_cnt frozen; resumes and completes remaining words after full=0.
4. Single req[3] pulse of 2 words then deasserts -> exactly 2 writes with req_data[63:48], IDLE next cycle, ptr=0 wraps so next req=0001 granted.
5. Force overflow=1 one cycle -> err_ovf=1 sticky; wr_en followed by wr_ack=0, overflow=0 -> err_ack=1; both clear only on rst.
6. With ARB_AFULL_THROTTLE_EN: almostfull=1 during producer0 burst at word 2 -> burst ends after that word; no new grant until almostfull=0.
